// File: rtl/rfsoc_config_pkg.sv
// Shared configuration for the RFSoC capture path: stream width and mux FSM states.
package rfsoc_config;

  // Width of the PS-facing AXI-Stream data bus.
  localparam int ps_axis_width = 32;

  // Packet mux arbitration state.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry AXI-Stream register slice. Output is driven from the head register;
// the skid register absorbs the one beat in flight when downstream stalls, so the
// upstream ready depends only on local state.
module axis_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         r_head_vld;
  logic         r_skid_vld;
  logic         w_push;
  logic         w_load_head;

  // Ready only needs the skid slot: a full skid means the head is also stalled.
  assign o_ready     = ~r_skid_vld;
  assign w_push      = i_valid & ~r_skid_vld;
  assign w_load_head = ~r_head_vld | i_ready;

  assign o_data  = r_head;
  assign o_valid = r_head_vld;

  // Head refills from the skid first (keeps order), otherwise from the input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: data registers are reset too so every output reads 0 during reset,
      // not just the valid flags.
      r_head     <= '0;
      r_skid     <= '0;
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_load_head) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      r_head_vld <= r_skid_vld | w_push;
      if (r_skid_vld) begin
        r_head <= r_skid;
      end else if (w_push) begin
        r_head <= i_data;
      end
      r_skid_vld <= 1'b0;
    end else if (w_push) begin
      r_skid     <= i_data;
      r_skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_n_mux_pkt.sv
// Packet-aware N:1 AXI-Stream mux. Arbitrates in IDLE (host select or round-robin),
// then stays locked on one channel until its tlast beat is accepted.
module axis_n_mux_pkt
  import rfsoc_config::*;
#(
  parameter int N_CH    = 16,
  parameter int DATA_W  = ps_axis_width,
  parameter bit RR_MODE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_CH-1:0]         select_in,
  input  logic [N_CH*DATA_W-1:0]  s_axis_tdata,
  input  logic [N_CH-1:0]         s_axis_tvalid,
  input  logic [N_CH-1:0]         s_axis_tlast,
  output logic [N_CH-1:0]         s_axis_tready,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [$clog2(N_CH)-1:0] active_ch,
  output logic                    busy,
  output logic                    sel_err
);

  localparam int CH_W = $clog2(N_CH);

  mux_state_t        r_state;
  mux_state_t        w_state_nxt;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_last_grant;
  logic [CH_W-1:0]   w_cand;
  logic              w_cand_found;
  logic              w_grant;
  logic              w_sel_onehot;
  logic              w_bad_sel;
  logic              r_bad_q;
  logic              r_sel_err;
  logic [DATA_W-1:0] w_s_data;
  logic              w_s_last;
  logic              w_s_valid;
  logic              w_s_ready;
  logic              w_accept;
  logic [DATA_W:0]   w_m_word;

  // Channel index k steps after base, wrapping at N_CH.
  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int k);
    int s;
    s = (int'(base) + 1 + k) % N_CH;
    return CH_W'(s);
  endfunction

  // Candidate encoder: lowest set select bit, or first valid channel after last grant.
  // Loops run downward so the last hit written is the highest-priority one.
  always_comb begin
    // NOTE: defaults first so no path leaves these unassigned (no latch).
    w_cand       = '0;
    w_cand_found = 1'b0;
    if (RR_MODE) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (s_axis_tvalid[rr_index(r_last_grant, k)]) begin
          w_cand       = rr_index(r_last_grant, k);
          w_cand_found = 1'b1;
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (select_in[i]) begin
          w_cand       = CH_W'(i);
          w_cand_found = 1'b1;
        end
      end
    end
  end

  assign w_sel_onehot = (select_in != '0) &&
                        ((select_in & (select_in - {{(N_CH-1){1'b0}}, 1'b1})) == '0);
  assign w_bad_sel    = ~RR_MODE & (r_state == IDLE) & ~w_sel_onehot;
  assign w_grant      = (r_state == IDLE) & w_cand_found & s_axis_tvalid[w_cand];

  // Input mux from the granted channel; nothing is presented while arbitrating.
  assign w_s_data  = s_axis_tdata[int'(r_grant)*DATA_W +: DATA_W];
  assign w_s_last  = s_axis_tlast[r_grant];
  assign w_s_valid = (r_state == LOCKED) & s_axis_tvalid[r_grant];
  assign w_accept  = w_s_valid & w_s_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: lock on a grant, release on the accepted tlast beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = LOCKED;
      LOCKED:  if (w_accept && w_s_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant and round-robin pointer; pointer starts at N_CH-1 so channel 0 is first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant      <= '0;
      r_last_grant <= CH_W'(N_CH - 1);
    end else begin
      if (w_grant) r_grant <= w_cand;
      if (RR_MODE && w_accept && w_s_last) r_last_grant <= r_grant;
    end
  end

  // sel_err pulses once when a bad select first appears during arbitration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bad_q   <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_bad_q   <= w_bad_sel;
      r_sel_err <= w_bad_sel & ~r_bad_q;
    end
  end

  // Ready decode: only the granted channel sees the skid buffer's ready.
  always_comb begin
    s_axis_tready = '0;
    if (r_state == LOCKED) s_axis_tready[r_grant] = w_s_ready;
  end

  axis_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_data  ({w_s_last, w_s_data}),
    .i_valid (w_s_valid),
    .o_ready (w_s_ready),
    .o_data  (w_m_word),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready)
  );

  assign m_axis_tdata = w_m_word[DATA_W-1:0];
  assign m_axis_tlast = w_m_word[DATA_W];
  assign active_ch    = r_grant;
  assign busy         = (r_state == LOCKED);
  assign sel_err      = r_sel_err;

endmodule

// File: tb/tb_axis_n_mux_pkt.sv
// Scoreboard bench for axis_n_mux_pkt: one host-select instance and one round-robin
// instance. Per-channel source queues feed the inputs; expected beats are queued when
// stimulus is loaded and a monitor compares every output handshake.
module tb_axis_n_mux_pkt;
  import rfsoc_config::*;

  localparam int N_CH = 16;
  localparam int DW   = ps_axis_width;

  typedef struct packed {
    logic [3:0]    ch;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic                   clk;
  logic                   rstn;
  logic [N_CH-1:0]        select_in [2];
  logic [N_CH*DW-1:0]     s_tdata   [2];
  logic [N_CH-1:0]        s_tvalid  [2];
  logic [N_CH-1:0]        s_tlast   [2];
  logic [N_CH-1:0]        s_tready  [2];
  logic [DW-1:0]          m_tdata   [2];
  logic                   m_tvalid  [2];
  logic                   m_tlast   [2];
  logic                   m_tready  [2];
  logic [3:0]             act       [2];
  logic                   busy      [2];
  logic                   sel_err   [2];

  logic [DW:0] src_q [2][N_CH][$];
  beat_t       exp_q [2][$];
  int          out_cyc [2][$];
  int          busy_cnt [2];
  int          serr_cnt [2];
  int          rdy_cnt  [2][N_CH];
  int          m_cfg [2];          // 0: ready low, 1: ready high, 2: random
  int          cyc;
  int          n_vec;
  int          n_err;

  axis_n_mux_pkt #(.N_CH(N_CH), .DATA_W(DW), .RR_MODE(1'b0)) u_sel (
    .clk(clk), .rstn(rstn), .select_in(select_in[0]),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]),
    .s_axis_tready(s_tready[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready[0]), .active_ch(act[0]),
    .busy(busy[0]), .sel_err(sel_err[0]));

  axis_n_mux_pkt #(.N_CH(N_CH), .DATA_W(DW), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rstn(rstn), .select_in(select_in[1]),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]),
    .s_axis_tready(s_tready[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready[1]), .active_ch(act[1]),
    .busy(busy[1]), .sel_err(sel_err[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Downstream ready generator, updated just after each rising edge.
  initial begin
    m_tready[0] = 1'b0;
    m_tready[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        case (m_cfg[u])
          0:       m_tready[u] = 1'b0;
          1:       m_tready[u] = 1'b1;
          default: m_tready[u] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_side
    // Source driver: pops a beat after each handshake, presents the queue head.
    initial begin
      logic [N_CH-1:0] hs;
      logic [DW:0]     w;
      s_tvalid[g] = '0;
      s_tdata[g]  = '0;
      s_tlast[g]  = '0;
      forever begin
        @(negedge clk);
        hs = s_tvalid[g] & s_tready[g];
        @(posedge clk);
        #1;
        for (int c = 0; c < N_CH; c++) begin
          if (hs[c] && src_q[g][c].size() > 0) void'(src_q[g][c].pop_front());
          if (src_q[g][c].size() > 0) begin
            w = src_q[g][c][0];
            s_tvalid[g][c]          = 1'b1;
            s_tlast[g][c]           = w[DW];
            s_tdata[g][c*DW +: DW]  = w[DW-1:0];
          end else begin
            s_tvalid[g][c]          = 1'b0;
            s_tlast[g][c]           = 1'b0;
            s_tdata[g][c*DW +: DW]  = '0;
          end
        end
      end
    end

    // Monitor: scoreboard pops, stall stability, ready one-hot, event counters.
    initial begin
      beat_t          got;
      beat_t          e;
      logic           stall_pend;
      logic [DW:0]    stall_word;
      busy_cnt[g] = 0;
      serr_cnt[g] = 0;
      for (int c = 0; c < N_CH; c++) rdy_cnt[g][c] = 0;
      stall_pend = 1'b0;
      stall_word = '0;
      forever begin
        @(negedge clk);
        if (!rstn) begin
          stall_pend = 1'b0;
        end else begin
          if (stall_pend) begin
            check("stall_valid", 64'(m_tvalid[g]), 64'd1);
            check("stall_hold", 64'({m_tlast[g], m_tdata[g]}), 64'(stall_word));
          end
          check("tready_onehot", 64'($countones(s_tready[g]) <= 1), 64'd1);
          if (busy[g])    busy_cnt[g]++;
          if (sel_err[g]) serr_cnt[g]++;
          for (int c = 0; c < N_CH; c++) if (s_tready[g][c]) rdy_cnt[g][c]++;
          if (m_tvalid[g] && m_tready[g]) begin
            got.ch   = act[g];
            got.last = m_tlast[g];
            got.data = m_tdata[g];
            if (exp_q[g].size() == 0) begin
              check("unexpected_beat", 64'(got), 64'h0);
            end else begin
              e = exp_q[g].pop_front();
              check(g == 0 ? "sel_beat" : "rr_beat", 64'(got), 64'(e));
            end
            out_cyc[g].push_back(cyc);
          end
          stall_pend = m_tvalid[g] & ~m_tready[g];
          stall_word = {m_tlast[g], m_tdata[g]};
        end
      end
    end
  end

  // Queue an n-beat packet on channel ch; optionally record the expected output.
  task automatic load_pkt(input int u, input int ch, input int n,
                          input logic [DW-1:0] base, input bit expect_out);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      e.ch   = 4'(ch);
      e.last = (b == n - 1);
      e.data = base + DW'(b);
      src_q[u][ch].push_back({e.last, e.data});
      if (expect_out) exp_q[u].push_back(e);
    end
  endtask

  task automatic wait_drain(input int u, input int budget, input string name);
    for (int i = 0; i < budget && exp_q[u].size() != 0; i++) @(negedge clk);
    check(name, 64'(exp_q[u].size()), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c_load;
    int i0;
    int b0;
    int s0;
    int r0 [N_CH];
    int other;
    int k;
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    m_cfg[0] = 1;
    m_cfg[1] = 1;
    select_in[0] = 16'h0004;
    select_in[1] = 16'h0000;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("rst_m_tdata", 64'(m_tdata[0]), 64'd0);
    check("rst_busy_act", 64'({busy[0], act[0], sel_err[0]}), 64'd0);
    check("rst_s_tready", 64'(s_tready[0]), 64'd0);
    check("rst_rr_outputs", 64'({m_tvalid[1], busy[1], act[1]}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    idle(3);

    // 1: ch2 4-beat packet under select 0x0004.
    i0 = out_cyc[0].size();
    b0 = busy_cnt[0];
    for (int c = 0; c < N_CH; c++) r0[c] = rdy_cnt[0][c];
    c_load = cyc;
    load_pkt(0, 2, 4, 32'hA0, 1'b1);
    wait_drain(0, 50, "t1_drain");
    idle(3);
    check("t1_busy_cycles", 64'(busy_cnt[0] - b0), 64'd4);
    other = 0;
    for (int c = 0; c < N_CH; c++) if (c != 2) other += rdy_cnt[0][c] - r0[c];
    check("t1_other_tready", 64'(other), 64'd0);
    check("t1_ch2_tready_seen", 64'(rdy_cnt[0][2] > r0[2]), 64'd1);
    // tvalid rises the cycle after loading; first output 2 cycles later.
    check("t1_latency", 64'(out_cyc[0][i0] - (c_load + 1)), 64'd2);
    check("t1_rate", 64'(out_cyc[0][i0 + 3] - out_cyc[0][i0]), 64'd3);

    // 2: select moves to ch4 mid-packet; ch2 finishes first.
    i0 = out_cyc[0].size();
    load_pkt(0, 2, 8, 32'h200, 1'b1);
    load_pkt(0, 4, 4, 32'h400, 1'b1);
    k = 0;
    while (src_q[0][2].size() > 6 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t2_beat1_seen", 64'(src_q[0][2].size() <= 6), 64'd1);
    select_in[0] = 16'h0010;
    wait_drain(0, 100, "t2_drain");
    check("t2_active_ch", 64'(act[0]), 64'd4);
    if (out_cyc[0].size() >= i0 + 9) begin
      check("t2_in_pkt_rate", 64'(out_cyc[0][i0 + 7] - out_cyc[0][i0]), 64'd7);
      check("t2_pkt_gap", 64'(out_cyc[0][i0 + 8] - out_cyc[0][i0 + 7]), 64'd2);
    end else begin
      check("t2_out_count", 64'(out_cyc[0].size() - i0), 64'd12);
    end

    // 3: round-robin over ch0/ch3/ch7, then ch3 alone.
    for (int p = 0; p < 2; p++) begin
      load_pkt(1, 0, 2, 32'h1000 + DW'(p * 16), 1'b0);
      load_pkt(1, 3, 2, 32'h1300 + DW'(p * 16), 1'b0);
      load_pkt(1, 7, 2, 32'h1700 + DW'(p * 16), 1'b0);
    end
    for (int p = 0; p < 2; p++) begin
      load_pkt(1, 0, 0, '0, 1'b0);
    end
    begin
      beat_t e;
      int order [3] = '{0, 3, 7};
      for (int p = 0; p < 2; p++)
        for (int j = 0; j < 3; j++)
          for (int b = 0; b < 2; b++) begin
            e.ch   = 4'(order[j]);
            e.last = (b == 1);
            e.data = 32'h1000 + DW'(order[j] * 256) + DW'(p * 16) + DW'(b);
            exp_q[1].push_back(e);
          end
    end
    wait_drain(1, 200, "t3_rr_drain");
    for (int p = 0; p < 3; p++) load_pkt(1, 3, 2, 32'h3300 + DW'(p * 16), 1'b1);
    wait_drain(1, 200, "t3_rr_single_drain");

    // 4: 1000 beats on ch5 with random downstream ready.
    select_in[0] = 16'h0020;
    m_cfg[0] = 2;
    for (int p = 0; p < 40; p++) load_pkt(0, 5, 25, 32'h5000_0000 + DW'(p * 256), 1'b1);
    wait_drain(0, 6000, "t4_drain");
    m_cfg[0] = 1;
    idle(3);

    // 5: zero select -> no grant; multi-hot 0x0011 -> ch0 (lowest bit).
    s0 = serr_cnt[0];
    select_in[0] = 16'h0000;
    load_pkt(0, 0, 2, 32'hC0, 1'b1);
    idle(6);
    check("t5_zero_no_grant", 64'(busy[0]), 64'd0);
    check("t5_zero_sel_err", 64'(serr_cnt[0] - s0), 64'd1);
    check("t5_zero_pending", 64'(exp_q[0].size()), 64'd2);
    select_in[0] = 16'h0002;
    idle(3);
    s0 = serr_cnt[0];
    load_pkt(0, 4, 2, 32'hC4, 1'b0);
    select_in[0] = 16'h0011;
    k = 0;
    while (!busy[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t5_multi_grant", 64'({busy[0], act[0]}), 64'h10);
    select_in[0] = 16'h0002;
    wait_drain(0, 50, "t5_drain");
    idle(3);
    check("t5_multi_sel_err", 64'(serr_cnt[0] - s0), 64'd1);
    check("t5_ch4_untouched", 64'(src_q[0][4].size()), 64'd2);
    src_q[0][4].delete();
    select_in[0] = 16'h0004;
    idle(3);

    // 6: reset with a partial packet held in the skid buffer.
    m_cfg[0] = 0;
    idle(2);
    load_pkt(0, 2, 5, 32'h600, 1'b0);
    k = 0;
    while (src_q[0][2].size() > 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    idle(3);
    check("t6_backpressure", 64'(src_q[0][2].size()), 64'd3);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("t6_rst_m_out", 64'({m_tvalid[0], m_tlast[0], m_tdata[0]}), 64'd0);
    check("t6_rst_ctrl", 64'({busy[0], act[0], sel_err[0], s_tready[0]}), 64'd0);
    for (int c = 0; c < N_CH; c++) begin
      src_q[0][c].delete();
      src_q[1][c].delete();
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_cfg[0] = 1;
    idle(3);
    load_pkt(0, 2, 3, 32'h700, 1'b1);
    wait_drain(0, 50, "t6_after_reset");
    idle(3);
    check("end_sel_queue", 64'(exp_q[0].size()), 64'd0);
    check("end_rr_queue", 64'(exp_q[1].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
